// File: rtl/seg7_pkg.sv
// Shared constants for the eight-digit seven-segment scanner: segment bit
// positions, the active-low hex glyph table and the blank pattern.
package seg7_pkg;

    localparam int NUM_DIGITS = 8;

    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [7:0] BLANK = 8'hFF;

    // Active-low glyphs with the decimal point off; entry i is the pattern for nibble i.
    localparam logic [15:0][7:0] HEX_PATTERN = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/hex7seg_decode.sv
// Combinational nibble to active-low seven-segment glyph (segments a..g only;
// the decimal point is merged in by the scanner).
module hex7seg_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_segments
);

    assign o_segments = HEX_PATTERN[i_nibble][SEG_G:SEG_A];

endmodule

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment driver. Advances one digit per rising
// edge of clkdiv[SCAN_BIT] and latches the displayed word once per frame.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int SCAN_BIT = 17
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] clkdiv,
    input  logic [31:0] disp_data,
    input  logic [7:0]  point,
    input  logic        lz_en,
    output logic [7:0]  AN,
    output logic [7:0]  SEGMENT,
    output logic        frame_start
);

    logic        r_scanPrev;
    logic [2:0]  r_dig;
    logic [31:0] r_shadowData;
    logic [7:0]  r_shadowPoint;
    logic        r_shadowLz;
    logic        r_frameStart;
    logic        r_active;
    logic [7:0]  r_an;
    logic [7:0]  r_segment;

    logic        w_tick;
    logic        w_unusedDiv;
    logic [3:0]  w_nibble;
    logic [6:0]  w_pattern;
    logic [7:0]  w_blankMask;
    logic [7:0]  w_anNext;
    logic [7:0]  w_segNext;

    assign w_tick      = clkdiv[SCAN_BIT] & ~r_scanPrev;
    assign w_unusedDiv = ^clkdiv;

    // scan_prev resets high so a divider bit already set at reset release is not a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scanPrev    <= 1'b1;
            r_dig         <= 3'd7;
            r_shadowData  <= '0;
            r_shadowPoint <= '0;
            r_shadowLz    <= 1'b0;
            r_frameStart  <= 1'b0;
            r_active      <= 1'b0;
        end else begin
            r_scanPrev   <= clkdiv[SCAN_BIT];
            r_frameStart <= w_tick && (r_dig == 3'd7);
            if (w_tick) begin
                r_dig    <= r_dig + 3'd1;
                r_active <= 1'b1;
                if (r_dig == 3'd7) begin
                    r_shadowData  <= disp_data;
                    r_shadowPoint <= point;
                    r_shadowLz    <= lz_en;
                end
            end
        end
    end

    assign w_nibble = r_shadowData[{r_dig, 2'b00} +: 4];

    hex7seg_decode u_decode (
        .i_nibble   (w_nibble),
        .o_segments (w_pattern)
    );

    // Shadow only changes at frame start, so this mask is effectively per-frame.
    always_comb begin
        w_blankMask = '0;
        for (int d = 1; d < NUM_DIGITS; d++) begin
            w_blankMask[d] = r_shadowLz && ((r_shadowData >> (4 * d)) == 32'd0);
        end
    end

    always_comb begin
        w_anNext  = BLANK;
        w_segNext = BLANK;
        if (!w_blankMask[r_dig]) begin
            w_anNext                = ~(8'b1 << r_dig);
            w_segNext[SEG_DP]       = ~r_shadowPoint[r_dig];
            w_segNext[SEG_G:SEG_A]  = w_pattern;
        end
    end

    // Outputs hold blank until the first tick has selected a digit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an      <= BLANK;
            r_segment <= BLANK;
        end else if (r_active) begin
            r_an      <= w_anNext;
            r_segment <= w_segNext;
        end
    end

    assign AN          = r_an;
    assign SEGMENT     = r_segment;
    assign frame_start = r_frameStart;

endmodule
